muldiv_iter: RTL and testbench

Iterative multiply/divide unit for the execute stage, replacing the fixed 1-bit-per-cycle shift-add/restoring engine. It is parametrised in operand width and bits retired per cycle, and it produces both halves of the product or both quotient and remainder. It adds abort, constant latency and defined divide-by-zero and overflow results. The execute stage drives it with a start/done handshake and exposes `hi` as a writable register.

---
 rtl/muldiv_iter_if.sv | 31 +++
 rtl/muldiv_iter.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Execute-stage to muldiv_iter connection: start/done handshake, operands, results, hi write port.
// No latency of its own; carries registered outputs from the unit.
// Requester holds off start while busy; the unit drops start seen while busy.
interface muldiv_iter_if #(
  parameter int RV = 32
);
  logic          start;
  logic          div;
  logic          sgn;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          kill;
  logic          hi_we;
  logic [RV-1:0] hi_wdata;
  logic          busy;
  logic          done;
  logic [RV-1:0] lo;
  logic [RV-1:0] hi;

  // Execute stage side
  modport master (
    output start, div, sgn, a, b, kill, hi_we, hi_wdata,
    input  busy, done, lo, hi
  );

  // Multiply/divide unit side
  modport slave (
    input  start, div, sgn, a, b, kill, hi_we, hi_wdata,
    output busy, done, lo, hi
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide, BPC bits per cycle; optional signed support under MULDIV_SIGNED_EN.
// Latency: done at RV/BPC cycles after start (one more for signed ops), independent of operands.
// start is accepted only when not busy (IDLE or DONE); start while busy is dropped, kill aborts.
module muldiv_iter #(
  parameter int RV  = 32,
  parameter int BPC = 1
) (
  input logic           clk,
  input logic           reset,
  muldiv_iter_if.slave  bus
);

  localparam int ITER = RV / BPC;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_div;
  // mul: {hi,lo} accumulator; div: {remainder, dividend/quotient shift register}
  logic [2*RV-1:0] acc;
  // mul: multiplicand; div: divisor
  logic [RV-1:0]   opb;
  // mul: multiplier, consumed MSB first
  logic [RV-1:0]   mpl;
  logic            busy_q;
  logic            done_q;
  logic [RV-1:0]   lo_q;
  logic [RV-1:0]   hi_q;

  logic            idle_like;
  logic            accept;
  logic            hi_wr;
  logic [RV-1:0]   a_mag;
  logic [RV-1:0]   b_mag;
  logic [2*RV-1:0] acc_n;
  logic [RV-1:0]   mpl_n;
  logic [RV:0]     rem_sh;
  logic [RV-1:0]   q_sh;

`ifdef MULDIV_SIGNED_EN
  logic            op_sgn;
  logic            neg_p;   // product / quotient negative
  logic            neg_r;   // remainder negative (follows dividend)
  logic            dz;      // divide by zero: quotient stays all ones
  logic            a_neg;
  logic            b_neg;
  logic [2*RV-1:0] prod_fix;
  logic [RV-1:0]   fix_lo;
  logic [RV-1:0]   fix_hi;
`else
  logic            sgn_unused;
  assign sgn_unused = bus.sgn;
`endif

  // DONE behaves like IDLE for acceptance; kill beats start, start beats hi_we.
  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = idle_like && bus.start && !bus.kill;
  assign hi_wr     = idle_like && bus.hi_we && !accept;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;

  // Operand magnitudes at launch (raw operands when signed support is absent or sgn=0)
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
`ifdef MULDIV_SIGNED_EN
    a_neg = bus.sgn && bus.a[RV-1];
    b_neg = bus.sgn && bus.b[RV-1];
    if (a_neg) a_mag = -bus.a;
    if (b_neg) b_mag = -bus.b;
`endif
  end

  // One iteration cycle: BPC shift-add or restoring steps from registered state only
  always_comb begin
    acc_n  = acc;
    mpl_n  = mpl;
    rem_sh = '0;
    q_sh   = '0;
    for (int k = 0; k < BPC; k++) begin
      if (op_div) begin
        rem_sh = {acc_n[2*RV-1:RV], acc_n[RV-1]};
        q_sh   = {acc_n[RV-2:0], 1'b0};
        if (rem_sh >= {1'b0, opb}) begin
          rem_sh  = rem_sh - {1'b0, opb};
          q_sh[0] = 1'b1;
        end
        acc_n = {rem_sh[RV-1:0], q_sh};
      end else begin
        acc_n = {acc_n[2*RV-2:0], 1'b0} +
                (mpl_n[RV-1] ? {{RV{1'b0}}, opb} : {2*RV{1'b0}});
        mpl_n = {mpl_n[RV-2:0], 1'b0};
      end
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign correction of the unsigned magnitude result
  always_comb begin
    prod_fix = neg_p ? -acc : acc;
    fix_lo   = prod_fix[RV-1:0];
    fix_hi   = prod_fix[2*RV-1:RV];
    if (op_div) begin
      fix_lo = dz ? {RV{1'b1}} : (neg_p ? -acc[RV-1:0] : acc[RV-1:0]);
      fix_hi = neg_r ? -acc[2*RV-1:RV] : acc[2*RV-1:RV];
    end
  end
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      mpl    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
`ifdef MULDIV_SIGNED_EN
      op_sgn <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (hi_wr) hi_q <= bus.hi_wdata;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= CW'(ITER - 1);
            op_div <= bus.div;
            opb    <= bus.div ? b_mag : a_mag;
            mpl    <= b_mag;
            acc    <= bus.div ? {{RV{1'b0}}, a_mag} : {2*RV{1'b0}};
`ifdef MULDIV_SIGNED_EN
            op_sgn <= bus.sgn;
            neg_p  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= (bus.b == '0);
`endif
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= acc_n;
            mpl <= mpl_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
`ifdef MULDIV_SIGNED_EN
              if (op_sgn) begin
                state <= FIX;
              end else begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                lo_q   <= acc_n[RV-1:0];
                hi_q   <= acc_n[2*RV-1:RV];
              end
`else
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              lo_q   <= acc_n[RV-1:0];
              hi_q   <= acc_n[2*RV-1:RV];
`endif
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            lo_q   <= fix_lo;
            hi_q   <= fix_hi;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: driver pushes expected results, monitor checks them on done.
// Expected latency is checked per result; stray done pulses are flagged by the monitor.
// Directed vectors cover mul/div, divide by zero, sgn, back-to-back, kill, reset and hi writes.
module tb_muldiv_iter;
  localparam int RV   = 32;
  localparam int BPC  = 2;
  localparam int ITER = RV / BPC;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   id_n = 0;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_iter_if #(.RV(RV)) bus();

  muldiv_iter #(.RV(RV), .BPC(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int lat(input logic s);
`ifdef MULDIV_SIGNED_EN
    return s ? ITER + 1 : ITER;
`else
    return (s === 1'bx) ? -1 : ITER;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("lo#%0d", mon_e.id), bus.lo, mon_e.lo);
        chk($sformatf("hi#%0d", mon_e.id), bus.hi, mon_e.hi);
        chk($sformatf("done_cycle#%0d", mon_e.id), 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge; returns at a negedge with busy low (or after a timeout)
  task automatic wait_not_busy();
    for (int i = 0; i < 200; i++) begin
      if (bus.busy === 1'b0) return;
      @(negedge clk);
    end
    checks++;
    fails++;
    $display("FAIL busy_timeout: got busy=1 for 200 cycles, required busy=0");
  endtask

  task automatic issue(input logic d, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic push, input logic [31:0] elo, input logic [31:0] ehi);
    exp_t e;
    wait_not_busy();
    bus.start = 1'b1;
    bus.div   = d;
    bus.sgn   = s;
    bus.a     = av;
    bus.b     = bv;
    if (push) begin
      e.lo  = elo;
      e.hi  = ehi;
      e.cyc = cyc + 1 + lat(s);
      e.id  = id_n;
      id_n++;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    checks++;
    fails++;
    $display("FAIL done_timeout: got no done in 200 cycles, required done=1");
  endtask

  initial begin
    bus.start = 1'b0; bus.div = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    bus.kill = 1'b0; bus.hi_we = 1'b0; bus.hi_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);

    // Unsigned multiply and divide vectors
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE); wait_done();
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2); wait_done();
    issue(1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd100); wait_done();
    issue(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 32'h1); wait_done();
    issue(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0); wait_done();
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF, 32'hF); wait_done();
    issue(1'b1, 1'b0, 32'd5, 32'd9, 1'b1, 32'd0, 32'd5); wait_done();

    // sgn=1 vectors: signed results with the feature, plain unsigned results without
`ifdef MULDIV_SIGNED_EN
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF); wait_done();
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0); wait_done();
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF); wait_done();
`else
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'h1); wait_done();
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000); wait_done();
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFF1, 32'h4); wait_done();
`endif

    // Back-to-back: second start issued in the DONE cycle of the first
    issue(1'b0, 1'b0, 32'd7, 32'd6, 1'b1, 32'd42, 32'd0); wait_done();
    issue(1'b0, 1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 32'd0); wait_done();

    // hi write while idle changes hi only
    bus.hi_we = 1'b1; bus.hi_wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("hi_we_idle_hi", bus.hi, 32'h1234);
    chk("hi_we_idle_lo", bus.lo, 32'd12);

    // hi write together with start: start wins
    bus.hi_we = 1'b1; bus.hi_wdata = 32'hAAAA;
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    bus.hi_we = 1'b0;
    wait_done();

    // start and hi write during RUN are ignored
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.div = 1'b0; bus.a = 32'd5; bus.b = 32'd5;
    bus.hi_we = 1'b1; bus.hi_wdata = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done();
    repeat (ITER + 4) @(negedge clk);

    // kill mid-RUN: idle at next edge, never a done
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy", 32'(bus.busy), 32'd0);
    chk("kill_done", 32'(bus.done), 32'd0);
    repeat (ITER + 4) @(negedge clk);

    // kill with start while idle: nothing launched
    bus.start = 1'b1; bus.kill = 1'b1; bus.div = 1'b0; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_start_busy", 32'(bus.busy), 32'd0);
    repeat (ITER + 4) @(negedge clk);

    // Result in place before reset, then reset mid-RUN
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2); wait_done();
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_run_busy", 32'(bus.busy), 32'd0);
    chk("rst_run_done", 32'(bus.done), 32'd0);
    chk("rst_run_lo", bus.lo, 32'd0);
    chk("rst_run_hi", bus.hi, 32'd0);
    reset = 1'b0;
    repeat (ITER + 4) @(negedge clk);

    chk("pending_results", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, required test completion");
    $fatal(1, "watchdog");
  end
endmodule
